// File: rtl/ctrl_pkg.sv
// Shared types for the multicycle RV32I control FSM.
// State, ALU, immediate-format and mux-select encodings.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_BPASS = 4'd9
  } alu_op_t;

  typedef enum logic [2:0] {
    SEXT_ADDI = 3'd0,
    SEXT_SLLI = 3'd1,
    SEXT_SW   = 3'd2,
    SEXT_LUI  = 3'd3
  } sign_extend_t;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LUI    = 7'b0110111,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111
  } opcode_t;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_ALU   = 4'd7,
    WB_MEM   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    JALR     = 4'd11,
    TRAP     = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_TARGET = 2'd1,
    PC_ALU    = 2'd2
  } pc_src_sel_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_sel_t;

  localparam logic [6:0] F7_ALT = 7'b0100000;

endpackage

// File: rtl/ctrl_alu_decoder.sv
// Combinational map from instruction fields to ALU
// operation and immediate format.
module ctrl_alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic [6:0]   funct7,
  output alu_op_t      alu_op,
  output sign_extend_t sext
);

  logic    alt;
  alu_op_t base_op;

  assign alt = (funct7 == F7_ALT);

  // Shared funct3 table; callers override 000 and 101.
  always_comb begin
    base_op = ALU_ADD;
    unique case (funct3)
      3'b000: base_op = ALU_ADD;
      3'b001: base_op = ALU_SLL;
      3'b010: base_op = ALU_SLT;
      3'b011: base_op = ALU_SLT;
      3'b100: base_op = ALU_XOR;
      3'b101: base_op = ALU_SRL;
      3'b110: base_op = ALU_OR;
      3'b111: base_op = ALU_AND;
      default: base_op = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_op = ALU_ADD;
    sext   = SEXT_ADDI;
    case (opcode)
      OP_R: begin
        alu_op = base_op;
        if (funct3 == 3'b000 && alt)
          alu_op = ALU_SUB;
      end
      OP_I: begin
        alu_op = base_op;
        if (funct3 == 3'b101 && alt)
          alu_op = ALU_SRA;
        if (funct3 == 3'b001 || funct3 == 3'b101)
          sext = SEXT_SLLI;
      end
      OP_LUI: begin
        alu_op = ALU_BPASS;
        sext   = SEXT_LUI;
      end
      OP_STORE: sext = SEXT_SW;
      default: begin
        alu_op = ALU_ADD;
        sext   = SEXT_ADDI;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I main control FSM with memory handshake.
// Optional perf counters under CTRL_PERF_COUNT_EN.
module multicycle_control
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        alu_eq,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src_sel,
  output logic        reg_write,
  output logic [1:0]  result_sel,
  output logic        alu_src_b,
  output logic [3:0]  alu_op,
  output logic [2:0]  sign_extend_type,
  output logic [3:0]  state,
  output logic        instr_retired,
  output logic        illegal
`ifdef CTRL_PERF_COUNT_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
`endif
);

  state_t       state_q;
  state_t       state_d;
  alu_op_t      dec_alu_op;
  sign_extend_t dec_sext;
  logic         taken;

  ctrl_alu_decoder u_dec (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .alu_op (dec_alu_op),
    .sext   (dec_sext)
  );

  assign taken = (funct3 == 3'b000 &&  alu_eq)
              || (funct3 == 3'b001 && !alu_eq);

  assign state = reset ? FETCH : state_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:
        if (mem_ready) state_d = DECODE;
      DECODE:
        case (opcode)
          OP_R:      state_d = EXEC_R;
          OP_I:      state_d = EXEC_I;
          OP_LUI:    state_d = EXEC_I;
          OP_LOAD:   state_d = MEM_ADDR;
          OP_STORE:  state_d = MEM_ADDR;
          OP_BRANCH: state_d = BRANCH;
          OP_JAL:    state_d = JUMP;
          OP_JALR:   state_d = JALR;
          default:   state_d = TRAP;
        endcase
      EXEC_R:   state_d = WB_ALU;
      EXEC_I:   state_d = WB_ALU;
      MEM_ADDR:
        state_d = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
      MEM_RD:
        if (mem_ready) state_d = WB_MEM;
      MEM_WR:
        if (mem_ready) state_d = FETCH;
      WB_ALU:   state_d = FETCH;
      WB_MEM:   state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JUMP:     state_d = FETCH;
      JALR:     state_d = FETCH;
      TRAP:     state_d = TRAP;
      default:  state_d = TRAP;
    endcase
  end

  // Reset masks every strobe so an abandoned instruction
  // cannot write anything on its last cycle.
  always_comb begin
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    addr_sel         = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_src_sel       = PC_PLUS4;
    reg_write        = 1'b0;
    result_sel       = RES_ALU;
    alu_src_b        = 1'b0;
    alu_op           = ALU_ADD;
    sign_extend_type = SEXT_ADDI;
    instr_retired    = 1'b0;
    illegal          = 1'b0;
    if (!reset) begin
      unique case (state_q)
        FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        EXEC_R: alu_op = dec_alu_op;
        EXEC_I, MEM_ADDR: begin
          alu_src_b        = 1'b1;
          alu_op           = dec_alu_op;
          sign_extend_type = dec_sext;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          addr_sel = 1'b1;
        end
        MEM_WR: begin
          mem_write     = 1'b1;
          addr_sel      = 1'b1;
          instr_retired = mem_ready;
        end
        WB_ALU: begin
          reg_write     = 1'b1;
          instr_retired = 1'b1;
        end
        WB_MEM: begin
          reg_write     = 1'b1;
          result_sel    = RES_MEM;
          instr_retired = 1'b1;
        end
        BRANCH: begin
          instr_retired = 1'b1;
          if (taken) begin
            pc_write   = 1'b1;
            pc_src_sel = PC_TARGET;
          end
        end
        JUMP: begin
          reg_write     = 1'b1;
          result_sel    = RES_PC4;
          pc_write      = 1'b1;
          pc_src_sel    = PC_TARGET;
          instr_retired = 1'b1;
        end
        JALR: begin
          alu_src_b        = 1'b1;
          alu_op           = dec_alu_op;
          sign_extend_type = dec_sext;
          reg_write        = 1'b1;
          result_sel       = RES_PC4;
          pc_write         = 1'b1;
          pc_src_sel       = PC_ALU;
          instr_retired    = 1'b1;
        end
        TRAP: illegal = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CTRL_PERF_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      cycle_count   <= cycle_count + 32'd1;
      instret_count <= instret_count
                     + {31'd0, instr_retired};
    end
  end
`endif

endmodule

// File: doc/multicycle_control.md
# multicycle_control

- Main control FSM for the multicycle variant of the RV32I core.
- Sequences one shared ALU and one shared instruction/data memory port through fetch, decode, execute, memory and writeback steps.
- Waits on a memory ready handshake, so slow memories stall the core cleanly.
- Sits between the instruction register and the datapath enables, replacing the single-cycle combinational control path.

## Interface
- No parameters.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- opcode  in  7  instruction register bits [6:0].
- funct3  in  3  instruction register bits [14:12].
- funct7  in  7  instruction register bits [31:25].
- alu_eq  in  1  ALU operand equality flag.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- mem_read  out  1  memory read request; held until mem_ready.
- mem_write  out  1  memory write request; held until mem_ready.
- addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result register.
- ir_write  out  1  load instruction register and old-PC register.
- pc_write  out  1  load PC from the pc_src_sel mux.
- pc_src_sel  out  2  0 = PC+4, 1 = branch/JAL target, 2 = ALU result.
- reg_write  out  1  register file write.
- result_sel  out  2  register data source: 0 = ALU result register, 1 = memory data register, 2 = old PC+4.
- alu_src_b  out  1  ALU B input: 0 = rs2, 1 = imm_ext.
- alu_op  out  4  ALU operation encoding.
- sign_extend_type  out  3  immediate format selector.
- state  out  4  current FSM state, for debug.
- instr_retired  out  1  one-cycle pulse on the final cycle of each instruction.
- illegal  out  1  high while in TRAP.

## Operation
- Encodings:
  - alu_op: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, BPASS=9.
  - sign_extend_type: ADDI=0, SLLI=1, SW=2, LUI=3.
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, JALR, TRAP.
- FETCH:
  - mem_read=1, addr_sel=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src_sel=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: no strobes. Dispatch on opcode:
  - 0110011 → EXEC_R
  - 0010011 or 0110111 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JUMP
  - 1100111 → JALR
  - anything else → TRAP
- EXEC_R → WB_ALU. alu_op decoded from funct3/funct7:
  - 000 → ADD, or SUB when funct7=0100000
  - 001 → SLL
  - 010 and 011 → SLT
  - 100 → XOR
  - 101 → SRL
  - 110 → OR
  - 111 → AND
- EXEC_I → WB_ALU. alu_src_b=1.
  - funct3 001/101 use SLLI format; 101 with funct7=0100000 → SRA.
  - funct3 010/011 → SLT.
  - LUI uses BPASS with LUI format.
- MEM_ADDR: ADD, alu_src_b=1; ADDI format for loads, SW format for stores. Loads → MEM_RD, stores → MEM_WR.
- MEM_RD: mem_read=1, addr_sel=1. On mem_ready → WB_MEM.
- MEM_WR: mem_write=1, addr_sel=1. On mem_ready → FETCH with instr_retired=1.
- WB_ALU and WB_MEM: reg_write=1 with result_sel 0 and 1 respectively; instr_retired=1; then FETCH.
- BRANCH:
  - Taken when funct3=000 and alu_eq=1, or funct3=001 and alu_eq=0. Other funct3 values are never taken.
  - When taken: pc_write=1, pc_src_sel=1.
  - Always instr_retired=1, then FETCH.
- JUMP: reg_write=1, result_sel=2, pc_write=1, pc_src_sel=1, instr_retired=1, then FETCH.
- JALR: ADD with ADDI format and alu_src_b=1; reg_write=1, result_sel=2, pc_write=1, pc_src_sel=2, instr_retired=1, then FETCH.
- TRAP: all strobes 0, illegal=1. Exit only via reset.
- Outputs are a combinational decode of state, opcode, funct fields, alu_eq and mem_ready.
- Select outputs are 0 in every state that does not name them.

## Timing
- Reset:
  - reset sampled high → state=FETCH on the next edge.
  - While reset is high, every output is forced to 0 (including mem_read and illegal) and state reads FETCH.
- Latency with mem_ready tied high:
  - R/I-type and LUI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/BNE, JAL, JALR: 3 cycles.
- Each cycle mem_ready is low in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- Requests stay asserted and stable until accepted; mem_ready in any other state is ignored.
- Reset mid-instruction: the instruction is abandoned and no write strobe is issued in that cycle.
- ir_write and pc_write in FETCH occur on the same edge.

## Configuration
- CTRL_PERF_COUNT_EN defined:
  - Adds outputs cycle_count (32) and instret_count (32), both reset to 0.
  - cycle_count increments every non-reset cycle.
  - instret_count increments on instr_retired.
  - Both wrap from 0xFFFFFFFF to 0.
- CTRL_PERF_COUNT_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package ctrl_pkg holds:
  - alu_op_t, sign_extend_t, opcode_t
  - state_t
  - pc_src_sel_t, result_sel_t
- One sub-module: ctrl_alu_decoder, a combinational map from (opcode, funct3, funct7) to alu_op and sign_extend_type.

## Test plan
- ADDI x1,x0,5 with mem_ready=1:
  - States FETCH, DECODE, EXEC_I, WB_ALU.
  - alu_op=0, alu_src_b=1, reg_write in cycle 4 only, one instr_retired pulse.
- LW with mem_ready low for 3 cycles in MEM_RD:
  - mem_read and addr_sel=1 held for 4 cycles.
  - WB_MEM follows with result_sel=1; total 8 cycles.
- BNE:
  - alu_eq=0 → pc_write=1, pc_src_sel=1.
  - alu_eq=1 → pc_write=0.
  - Both cases last 3 cycles.
- JAL then JALR:
  - Both give reg_write=1 and result_sel=2.
  - pc_src_sel=1 for JAL and 2 for JALR.
- Opcode 0x7F:
  - TRAP entered after DECODE; illegal=1 with no strobes for 10 cycles.
  - Reset returns the FSM to FETCH.
- Reset asserted during MEM_WR:
  - mem_write=0 that cycle; state=FETCH after the edge.
  - With CTRL_PERF_COUNT_EN defined, both counters read 0.
